qlearn_episode_ctrl: RTL and testbench
======================================

Name: qlearn_episode_ctrl

Overview:
- Sequences the 4-stage Q-learning update pipeline across training episodes.
- Issues one action per cycle, choosing between an exploring action (from an internal LFSR, epsilon-greedy) and the greedy action supplied by the datapath.
- Ends an episode on the terminal state or a step limit, drains in-flight updates, and restarts the pipeline's state register.
- Counts steps and episodes and signals completion to the host/testbench.

Parameters:
- PIPE_DEPTH, 4, drain cycles after the last action of an episode (pipeline latency).
- STEP_W, 10, width of step counter and max_steps.
- EP_W, 12, width of episode counter and num_episodes.
- TERM_STATE, 6'b111111, goal state on the 8x8 grid that ends an episode.
- LFSR_SEED, 16'hACE1, LFSR value loaded on rst; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  1-cycle pulse; begins a training run (sampled in IDLE only)
- abort  in  1  ends the run at the next cycle; drains the pipeline, then goes to DONE
- num_episodes  in  EP_W  episodes per run, sampled on start
- max_steps  in  STEP_W  step limit per episode, sampled on start; 0 treated as 1
- epsilon  in  8  explore threshold; explore when lfsr[7:0] < epsilon
- greedy_action  in  2  argmax action at the current state, from datapath
- cur_state  in  6  pipeline's current state s
- action  out  2  action to pipeline
- action_valid  out  1  action is a real step this cycle
- pipe_rst  out  1  1-cycle pulse resetting the pipeline state to 0
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse at run end
- episode_cnt  out  EP_W  completed episodes in current run
- step_cnt  out  STEP_W  actions issued in current episode

Behaviour:
- Reset: state=IDLE; lfsr=LFSR_SEED; action=0, action_valid=0, pipe_rst=0, busy=0, done=0, episode_cnt=0, step_cnt=0; latched limits cleared.
- States: IDLE, INIT, RUN, DRAIN, RESTART, DONE.
- IDLE:
  - On start, latch num_episodes/max_steps and clear both counters.
  - If num_episodes==0, go to DONE; else go to INIT.
  - start in any other state is ignored.
- INIT: pipe_rst=1 for exactly this cycle, then RUN.
- RUN:
  - Each cycle: action_valid=1, step_cnt++, lfsr advances one step (Fibonacci, taps 16,14,13,11; feedback enters bit 0).
  - Action selection from the pre-advance lfsr: if lfsr[7:0] < epsilon, action = lfsr[9:8]; else action = greedy_action.
  - action, action_valid and step_cnt are registered; the action is visible the cycle after selection.
- Episode end (evaluated in RUN):
  - Terminal: cur_state==TERM_STATE.
  - Step limit: step_cnt (after increment) == max_steps.
  - Abort: abort==1.
  - On any of these, the next cycle is DRAIN with action_valid=0.
  - Terminal and step limit in the same cycle count as one episode end.
- DRAIN:
  - Waits exactly PIPE_DEPTH cycles with action_valid=0 and lfsr frozen.
  - Exit: to DONE if aborted or if episode_cnt+1 == num_episodes; else to RESTART.
  - The exit cycle increments episode_cnt unless the episode ended by abort.
- RESTART: pipe_rst=1 for one cycle, step_cnt=0, then RUN.
- DONE: done=1 for one cycle, then IDLE. Counters hold their final values until the next start.
- abort outside RUN/DRAIN has no effect. abort during DRAIN marks the run aborted; the drain still completes.
- episode_cnt saturates at all-ones; step_cnt never exceeds max_steps.
- rst mid-run returns to IDLE next edge with all reset values. No done pulse is produced.
- No combinational path from any input to any output.

Test Plan:
- rst, epsilon=0, greedy_action=2'b10, num_episodes=1, max_steps=5, start -> pipe_rst one cycle, then 5 consecutive action_valid with action=2'b10, 4 idle cycles, then done; episode_cnt=1, step_cnt=5.
- epsilon=255 from reset seed -> first 8 actions equal bits [9:8] of the successive LFSR values starting 16'hACE1; compare against a bench LFSR model. Any cycle with lfsr[7:0]==8'hFF uses greedy_action.
- cur_state driven to 6'b111111 on the 3rd RUN cycle, max_steps=100, num_episodes=2 -> action_valid stops after 3 steps, 4 drain cycles, pipe_rst, step_cnt=0, second episode begins.
- num_episodes=0, start -> done pulses 2 cycles after start; no pipe_rst and no action_valid.
- abort on RUN step 2 of episode 1 of 3 -> 4 drain cycles, done pulse, episode_cnt=0; a start pulse during the run is ignored.
- rst asserted in DRAIN -> next cycle busy=0, all outputs at reset values, lfsr=16'hACE1 (next run's actions match a fresh run).

Source files
------------

// File: rtl/qlearn_episode_ctrl.sv
// ---------------------------------------------------------------------------
// qlearn_episode_ctrl
//
// Episode sequencer for a 4-stage Q-learning update pipeline. It issues one
// action per cycle during an episode, chooses between an exploring action
// from an internal LFSR and the datapath's greedy action (epsilon-greedy),
// and ends an episode on the goal state, a step limit or an abort. After an
// episode ends it drains the in-flight updates and then either restarts the
// pipeline for the next episode or finishes the run.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset
//   start          1-cycle pulse, begins a run (only honoured in IDLE)
//   abort          ends the run; the pipeline is drained before DONE
//   num_episodes   episodes per run, latched on start
//   max_steps      step limit per episode, latched on start (0 acts as 1)
//   epsilon        explore when lfsr[7:0] < epsilon
//   greedy_action  argmax action at the current state, from the datapath
//   cur_state      pipeline's current state s
//   action         registered action to the pipeline
//   action_valid   action is a real step this cycle
//   pipe_rst       1-cycle pulse that resets the pipeline state to 0
//   busy           high whenever the controller is not IDLE
//   done           1-cycle pulse at the end of a run
//   episode_cnt    completed episodes in the current run
//   step_cnt       actions issued in the current episode
//
// Timing notes
//   The action for a RUN cycle is selected in the cycle before it and loaded
//   on the clock edge that enters that RUN cycle, so action_valid is high in
//   exactly the RUN cycles. step_cnt counts the action currently on the bus.
//   done is raised on the edge that leaves DONE, so it appears in the first
//   IDLE cycle after the run (two cycles after start for a zero-episode run).
// ---------------------------------------------------------------------------
module qlearn_episode_ctrl #(
    parameter int          PIPE_DEPTH = 4,
    parameter int          STEP_W     = 10,
    parameter int          EP_W       = 12,
    parameter logic [5:0]  TERM_STATE = 6'b111111,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [EP_W-1:0]   num_episodes,
    input  logic [STEP_W-1:0] max_steps,
    input  logic [7:0]        epsilon,
    input  logic [1:0]        greedy_action,
    input  logic [5:0]        cur_state,
    output logic [1:0]        action,
    output logic              action_valid,
    output logic              pipe_rst,
    output logic              busy,
    output logic              done,
    output logic [EP_W-1:0]   episode_cnt,
    output logic [STEP_W-1:0] step_cnt
);

    localparam int DCW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_RESTART,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [1:0]        sel_action;
    logic              explore;

    logic [EP_W-1:0]   lim_episodes;
    logic [STEP_W-1:0] lim_steps;
    logic              aborted;
    logic [DCW-1:0]    drain_cnt;

    logic              episode_end;
    logic              drain_last;
    logic              abort_seen;
    logic              finish_run;

    // Fibonacci LFSR step (taps 16,14,13,11, feedback into bit 0) and the
    // epsilon-greedy choice, both taken from the current (pre-advance) value.
    always_comb begin
        lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        explore    = (lfsr[7:0] < epsilon);
        sel_action = explore ? lfsr[9:8] : greedy_action;
    end

    // Decision terms shared by the next-state logic and the datapath
    // registers. An abort arriving in the last drain cycle still counts,
    // and the episode comparison is one bit wider so it cannot wrap.
    always_comb begin
        episode_end = (cur_state == TERM_STATE) || (step_cnt == lim_steps) || abort;
        drain_last  = (drain_cnt == DCW'(PIPE_DEPTH - 1));
        abort_seen  = aborted || abort;
        finish_run  = abort_seen ||
                      (({1'b0, episode_cnt} + {{EP_W{1'b0}}, 1'b1}) == {1'b0, lim_episodes});
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the episode sequence.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (num_episodes == '0) ? S_DONE : S_INIT;
                end
            end
            S_INIT:    next_state = S_RUN;
            S_RUN: begin
                if (episode_end) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    next_state = finish_run ? S_DONE : S_RESTART;
                end
            end
            S_RESTART: next_state = S_RUN;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Outputs decoded purely from the state register.
    always_comb begin
        busy     = (state != S_IDLE);
        pipe_rst = (state == S_INIT) || (state == S_RESTART);
    end

    // Datapath registers: LFSR, action bus, counters, latched limits and the
    // abort flag. Anything that feeds the next RUN cycle is loaded on the
    // edge that enters RUN, so the LFSR only moves when a step is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr         <= LFSR_SEED;
            action       <= '0;
            action_valid <= 1'b0;
            done         <= 1'b0;
            episode_cnt  <= '0;
            step_cnt     <= '0;
            lim_episodes <= '0;
            lim_steps    <= '0;
            aborted      <= 1'b0;
            drain_cnt    <= '0;
        end else begin
            action_valid <= (next_state == S_RUN);
            done         <= (state == S_DONE);
            drain_cnt    <= (state == S_DRAIN) ? drain_cnt + DCW'(1) : '0;

            if (next_state == S_RUN) begin
                lfsr     <= lfsr_next;
                action   <= sel_action;
                step_cnt <= step_cnt + STEP_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        lim_episodes <= num_episodes;
                        lim_steps    <= (max_steps == '0) ? STEP_W'(1) : max_steps;
                        episode_cnt  <= '0;
                        step_cnt     <= '0;
                        aborted      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                    if (drain_last) begin
                        if (!abort_seen && (episode_cnt != '1)) begin
                            episode_cnt <= episode_cnt + EP_W'(1);
                        end
                        if (!finish_run) begin
                            step_cnt <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qlearn_episode_ctrl
//
// Directed bench for qlearn_episode_ctrl. Inputs change on the falling edge
// and outputs are observed on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_qlearn_episode_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [11:0] num_episodes;
    logic [9:0]  max_steps;
    logic [7:0]  epsilon;
    logic [1:0]  greedy_action;
    logic [5:0]  cur_state;
    logic [1:0]  action;
    logic        action_valid;
    logic        pipe_rst;
    logic        busy;
    logic        done;
    logic [11:0] episode_cnt;
    logic [9:0]  step_cnt;

    int checks;
    int passed;

    qlearn_episode_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .num_episodes  (num_episodes),
        .max_steps     (max_steps),
        .epsilon       (epsilon),
        .greedy_action (greedy_action),
        .cur_state     (cur_state),
        .action        (action),
        .action_valid  (action_valid),
        .pipe_rst      (pipe_rst),
        .busy          (busy),
        .done          (done),
        .episode_cnt   (episode_cnt),
        .step_cnt      (step_cnt)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR: Fibonacci, taps 16,14,13,11, feedback into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [11:0] ne, input logic [9:0] ms);
        num_episodes = ne;
        max_steps    = ms;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (action_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", action_valid); else passed++;
        checks++; if (pipe_rst !== 1'b0) $display("[TB] FAIL reset_pipe_rst got %b want 0", pipe_rst); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (action !== 2'b00) $display("[TB] FAIL reset_action got %b want 00", action); else passed++;
        checks++; if (episode_cnt !== 12'd0) $display("[TB] FAIL reset_episode_cnt got %0d want 0", episode_cnt); else passed++;
        checks++; if (step_cnt !== 10'd0) $display("[TB] FAIL reset_step_cnt got %0d want 0", step_cnt); else passed++;
    endtask

    // epsilon=0: always greedy; 5-step limit, one episode.
    task automatic test_basic();
        epsilon       = 8'd0;
        greedy_action = 2'b10;
        cur_state     = 6'd0;
        pulse_start(12'd1, 10'd5);
        checks++; if (pipe_rst !== 1'b1) $display("[TB] FAIL basic_init_pipe_rst got %b want 1", pipe_rst); else passed++;
        checks++; if (action_valid !== 1'b0) $display("[TB] FAIL basic_init_valid got %b want 0", action_valid); else passed++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL basic_init_busy got %b want 1", busy); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (action_valid !== 1'b1) $display("[TB] FAIL basic_run_valid step %0d got %b want 1", i + 1, action_valid); else passed++;
            checks++; if (action !== 2'b10) $display("[TB] FAIL basic_run_action step %0d got %b want 10", i + 1, action); else passed++;
            checks++; if (step_cnt !== 10'(i + 1)) $display("[TB] FAIL basic_run_step_cnt got %0d want %0d", step_cnt, i + 1); else passed++;
            checks++; if (pipe_rst !== 1'b0) $display("[TB] FAIL basic_run_pipe_rst got %b want 0", pipe_rst); else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (action_valid !== 1'b0) $display("[TB] FAIL basic_drain_valid cycle %0d got %b want 0", i, action_valid); else passed++;
            checks++; if (busy !== 1'b1) $display("[TB] FAIL basic_drain_busy cycle %0d got %b want 1", i, busy); else passed++;
            checks++; if (done !== 1'b0) $display("[TB] FAIL basic_drain_done cycle %0d got %b want 0", i, done); else passed++;
        end
        tick();
        checks++; if (done !== 1'b0) $display("[TB] FAIL basic_donestate_done got %b want 0", done); else passed++;
        tick();
        checks++; if (done !== 1'b1) $display("[TB] FAIL basic_done got %b want 1", done); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_end_busy got %b want 0", busy); else passed++;
        checks++; if (episode_cnt !== 12'd1) $display("[TB] FAIL basic_episode_cnt got %0d want 1", episode_cnt); else passed++;
        checks++; if (step_cnt !== 10'd5) $display("[TB] FAIL basic_step_cnt got %0d want 5", step_cnt); else passed++;
        tick();
        checks++; if (done !== 1'b0) $display("[TB] FAIL basic_done_width got %b want 0", done); else passed++;
    endtask

    // epsilon=255: actions follow LFSR bits [9:8] except where lfsr[7:0]==FF.
    task automatic test_explore();
        logic [15:0] m;
        logic [1:0]  exp_a;
        do_reset();
        epsilon       = 8'd255;
        greedy_action = 2'b01;
        cur_state     = 6'd0;
        m             = 16'hACE1;
        pulse_start(12'd1, 10'd8);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_a = (m[7:0] < 8'd255) ? m[9:8] : greedy_action;
            checks++; if (action !== exp_a || action_valid !== 1'b1) $display("[TB] FAIL explore_action step %0d got %b/%b want %b/1", i + 1, action, action_valid, exp_a); else passed++;
            m = lfsr_step(m);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (busy !== 1'b0 || episode_cnt !== 12'd1) $display("[TB] FAIL explore_end got busy %b cnt %0d want 0/1", busy, episode_cnt); else passed++;
    endtask

    // Goal state on the 3rd step of episode 1, then on the 2nd of episode 2.
    task automatic test_terminal();
        epsilon       = 8'd0;
        greedy_action = 2'b11;
        cur_state     = 6'd0;
        pulse_start(12'd2, 10'd100);
        tick();
        tick();
        tick();
        cur_state = 6'b111111;
        checks++; if (action_valid !== 1'b1 || step_cnt !== 10'd3) $display("[TB] FAIL term_step3 got valid %b step %0d want 1/3", action_valid, step_cnt); else passed++;
        tick();
        cur_state = 6'd0;
        checks++; if (action_valid !== 1'b0) $display("[TB] FAIL term_drain_valid got %b want 0", action_valid); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (action_valid !== 1'b0 || pipe_rst !== 1'b0) $display("[TB] FAIL term_drain cycle %0d got valid %b pipe_rst %b want 0/0", i + 1, action_valid, pipe_rst); else passed++;
        end
        tick();
        checks++; if (pipe_rst !== 1'b1) $display("[TB] FAIL term_restart_pipe_rst got %b want 1", pipe_rst); else passed++;
        checks++; if (step_cnt !== 10'd0) $display("[TB] FAIL term_restart_step_cnt got %0d want 0", step_cnt); else passed++;
        checks++; if (episode_cnt !== 12'd1) $display("[TB] FAIL term_restart_episode_cnt got %0d want 1", episode_cnt); else passed++;
        tick();
        checks++; if (action_valid !== 1'b1 || step_cnt !== 10'd1 || action !== 2'b11) $display("[TB] FAIL term_ep2_first got valid %b step %0d action %b want 1/1/11", action_valid, step_cnt, action); else passed++;
        tick();
        cur_state = 6'b111111;
        tick();
        cur_state = 6'd0;
        checks++; if (action_valid !== 1'b0) $display("[TB] FAIL term_ep2_drain_valid got %b want 0", action_valid); else passed++;
        for (int i = 0; i < 4; i++) tick();
        tick();
        checks++; if (done !== 1'b1) $display("[TB] FAIL term_done got %b want 1", done); else passed++;
        checks++; if (episode_cnt !== 12'd2 || step_cnt !== 10'd2) $display("[TB] FAIL term_counts got ep %0d step %0d want 2/2", episode_cnt, step_cnt); else passed++;
    endtask

    // Zero episodes: straight to DONE, no pipeline activity.
    task automatic test_zero_episodes();
        pulse_start(12'd0, 10'd5);
        checks++; if (pipe_rst !== 1'b0 || action_valid !== 1'b0 || done !== 1'b0) $display("[TB] FAIL zero_c1 got pipe_rst %b valid %b done %b want 0/0/0", pipe_rst, action_valid, done); else passed++;
        tick();
        checks++; if (done !== 1'b1 || pipe_rst !== 1'b0 || action_valid !== 1'b0) $display("[TB] FAIL zero_c2 got done %b pipe_rst %b valid %b want 1/0/0", done, pipe_rst, action_valid); else passed++;
        checks++; if (episode_cnt !== 12'd0 || step_cnt !== 10'd0) $display("[TB] FAIL zero_counts got ep %0d step %0d want 0/0", episode_cnt, step_cnt); else passed++;
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL zero_after got done %b busy %b want 0/0", done, busy); else passed++;
    endtask

    // Abort on step 2 of a 3-episode run; a stray start mid-run is ignored.
    task automatic test_abort();
        epsilon       = 8'd0;
        greedy_action = 2'b01;
        cur_state     = 6'd0;
        pulse_start(12'd3, 10'd10);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        checks++; if (step_cnt !== 10'd2 || action_valid !== 1'b1) $display("[TB] FAIL abort_step2 got step %0d valid %b want 2/1", step_cnt, action_valid); else passed++;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++; if (action_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) $display("[TB] FAIL abort_drain cycle %0d got valid %b busy %b done %b want 0/1/0", i, action_valid, busy, done); else passed++;
        end
        tick();
        checks++; if (pipe_rst !== 1'b0 || done !== 1'b0) $display("[TB] FAIL abort_no_restart got pipe_rst %b done %b want 0/0", pipe_rst, done); else passed++;
        tick();
        checks++; if (done !== 1'b1) $display("[TB] FAIL abort_done got %b want 1", done); else passed++;
        checks++; if (episode_cnt !== 12'd0 || step_cnt !== 10'd2) $display("[TB] FAIL abort_counts got ep %0d step %0d want 0/2", episode_cnt, step_cnt); else passed++;
        tick();
        checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_idle_busy got %b want 0", busy); else passed++;
    endtask

    // Reset during DRAIN, then a fresh run must replay the seed sequence.
    task automatic test_reset_mid_drain();
        logic [15:0] m;
        logic [1:0]  exp_a;
        epsilon       = 8'd255;
        greedy_action = 2'b00;
        cur_state     = 6'd0;
        pulse_start(12'd1, 10'd3);
        for (int i = 0; i < 5; i++) tick();
        checks++; if (busy !== 1'b1 || action_valid !== 1'b0) $display("[TB] FAIL rstdrain_in_drain got busy %b valid %b want 1/0", busy, action_valid); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || action_valid !== 1'b0 || pipe_rst !== 1'b0 || done !== 1'b0) $display("[TB] FAIL rstdrain_flags got busy %b valid %b pipe_rst %b done %b want 0/0/0/0", busy, action_valid, pipe_rst, done); else passed++;
        checks++; if (action !== 2'b00 || episode_cnt !== 12'd0 || step_cnt !== 10'd0) $display("[TB] FAIL rstdrain_values got action %b ep %0d step %0d want 00/0/0", action, episode_cnt, step_cnt); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL rstdrain_quiet cycle %0d got done %b busy %b want 0/0", i, done, busy); else passed++;
        end
        greedy_action = 2'b10;
        m = 16'hACE1;
        pulse_start(12'd1, 10'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_a = (m[7:0] < 8'd255) ? m[9:8] : greedy_action;
            checks++; if (action !== exp_a || action_valid !== 1'b1) $display("[TB] FAIL rstdrain_replay step %0d got %b/%b want %b/1", i + 1, action, action_valid, exp_a); else passed++;
            m = lfsr_step(m);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (busy !== 1'b0 || step_cnt !== 10'd4) $display("[TB] FAIL rstdrain_end got busy %b step %0d want 0/4", busy, step_cnt); else passed++;
    endtask

    initial begin
        checks        = 0;
        passed        = 0;
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        num_episodes  = '0;
        max_steps     = '0;
        epsilon       = '0;
        greedy_action = '0;
        cur_state     = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_explore();
        test_terminal();
        test_zero_episodes();
        test_abort();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
